// File: rtl/jtpang_pkg.sv
// rtl/jtpang_pkg.sv - shared state encoding and default sizes for the jtpang object DMA
//
// Purpose: FSM state encoding and default transfer parameters used by
// jtpang_objdma. No ports.
package jtpang_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_REQ  = 3'd1,
    ST_RD   = 3'd2,
    ST_WR   = 3'd3,
    ST_REL  = 3'd4
  } objdma_state_e;

  localparam int          DEF_LEN      = 512;
  localparam int          DEF_AW       = 9;
  localparam logic [11:0] DEF_SRC_BASE = 12'h000;

endpackage

// File: rtl/jtpang_objdma.sv
// rtl/jtpang_objdma.sv - object RAM DMA engine driving the main CPU BUSRQ/BUSAK handshake
//
// Purpose: on a rising edge of dma_go, request the CPU bus, copy LEN bytes from
// the shared bus starting at SRC_BASE into the object RAM, then release the bus.
// All state changes happen on cen.
//
// Optional feature: define JTPANG_DMA_LVBL_EN to hold a pending request until
// vertical blank (LVBL low). Without it LVBL is ignored.
//
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   cen            CPU clock enable
//   dma_go         start strobe (rising edge)
//   busak_n        CPU bus acknowledge, active low
//   LVBL           vertical blank, active low
//   busrq_n        bus request, active low
//   src_addr/cs    shared-bus read address and strobe
//   src_dout       shared-bus read data
//   obj_addr/din   object RAM write address and data
//   obj_we         object RAM write enable
//   busy           transfer in progress (request to release)
module jtpang_objdma
  import jtpang_pkg::*;
#(
  parameter int          LEN      = DEF_LEN,
  parameter int          AW       = DEF_AW,
  parameter logic [11:0] SRC_BASE = DEF_SRC_BASE
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cen,
  input  logic          dma_go,
  input  logic          busak_n,
  input  logic          LVBL,
  output logic          busrq_n,
  output logic [11:0]   src_addr,
  output logic          src_cs,
  input  logic [7:0]    src_dout,
  output logic [AW-1:0] obj_addr,
  output logic [7:0]    obj_din,
  output logic          obj_we,
  output logic          busy
);

  localparam logic [AW:0] LAST = (AW+1)'(LEN - 1);

  objdma_state_e state_q, state_d;
  logic          go_l_q;
  logic          pending_q, pending_d;
  logic [AW:0]   count_q, count_d;
  logic          busrq_n_q, busrq_n_d;
  logic          src_cs_q, src_cs_d;
  logic [11:0]   src_addr_q, src_addr_d;
  logic          obj_we_q, obj_we_d;
  logic [AW-1:0] obj_addr_q, obj_addr_d;
  logic [7:0]    obj_din_q, obj_din_d;
  logic          busy_q, busy_d;
  logic          go_edge;
  logic          start_ok;

`ifdef JTPANG_DMA_LVBL_EN
  assign start_ok = ~LVBL;
`else
  logic unused_lvbl;
  assign unused_lvbl = LVBL;
  assign start_ok    = 1'b1;
`endif

  assign go_edge = dma_go & ~go_l_q;

  always_comb begin
    state_d    = state_q;
    // one-deep request latch: extra edges while already pending are lost
    pending_d  = pending_q | go_edge;
    count_d    = count_q;
    busrq_n_d  = busrq_n_q;
    src_cs_d   = src_cs_q;
    src_addr_d = src_addr_q;
    obj_we_d   = 1'b0;
    obj_addr_d = obj_addr_q;
    obj_din_d  = obj_din_q;
    busy_d     = busy_q;
    if (cen) begin
      case (state_q)
        ST_IDLE: if (pending_q && start_ok) begin
          state_d   = ST_REQ;
          // an edge landing on the very cycle we consume the request survives
          pending_d = go_edge;
          busy_d    = 1'b1;
          busrq_n_d = 1'b0;
          count_d   = '0;
        end
        ST_REQ: if (!busak_n) state_d = ST_RD;
        // RD/WR stall while the CPU has taken the bus back
        ST_RD: if (!busak_n) begin
          src_addr_d = SRC_BASE + 12'(count_q);
          src_cs_d   = 1'b1;
          state_d    = ST_WR;
        end
        ST_WR: if (!busak_n) begin
          obj_addr_d = count_q[AW-1:0];
          obj_din_d  = src_dout;
          obj_we_d   = 1'b1;
          if (count_q == LAST) begin
            state_d = ST_REL;
          end else begin
            count_d = count_q + (AW+1)'(1);
            state_d = ST_RD;
          end
        end
        ST_REL: begin
          busrq_n_d = 1'b1;
          src_cs_d  = 1'b0;
          busy_d    = 1'b0;
          state_d   = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // obj_we is high for the single clk following the cen edge that does the write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      go_l_q     <= 1'b0;
      pending_q  <= 1'b0;
      count_q    <= '0;
      busrq_n_q  <= 1'b1;
      src_cs_q   <= 1'b0;
      src_addr_q <= SRC_BASE;
      obj_we_q   <= 1'b0;
      obj_addr_q <= '0;
      obj_din_q  <= 8'd0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      go_l_q     <= dma_go;
      pending_q  <= pending_d;
      count_q    <= count_d;
      busrq_n_q  <= busrq_n_d;
      src_cs_q   <= src_cs_d;
      src_addr_q <= src_addr_d;
      obj_we_q   <= obj_we_d;
      obj_addr_q <= obj_addr_d;
      obj_din_q  <= obj_din_d;
      busy_q     <= busy_d;
    end
  end

  assign busrq_n  = busrq_n_q;
  assign src_cs   = src_cs_q;
  assign src_addr = src_addr_q;
  assign obj_we   = obj_we_q;
  assign obj_addr = obj_addr_q;
  assign obj_din  = obj_din_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_jtpang_objdma.sv
// tb/tb_jtpang_objdma.sv - self-checking bench for jtpang_objdma
module tb_jtpang_objdma;

  localparam int LEN = 512;

  logic        clk, rst_n, cen, dma_go, busak_n, LVBL;
  logic        busrq_n_a, src_cs_a, obj_we_a, busy_a;
  logic        busrq_n_b, src_cs_b, obj_we_b, busy_b;
  logic [11:0] src_addr_a, src_addr_b;
  logic [7:0]  src_dout_a, src_dout_b, obj_din_a, obj_din_b;
  logic [8:0]  obj_addr_a, obj_addr_b;

  logic [7:0]  mem [4096];
  int          n_cmp = 0, n_fail = 0;
  int          wr_idx = 0, xfers_total = 0;
  logic        cen_smp = 1'b0, busak_smp = 1'b1, force_hi = 1'b0;
  int          ack_dly;

  assign src_dout_a = mem[src_addr_a];
  assign src_dout_b = mem[src_addr_b];

  jtpang_objdma dut_a (
    .clk(clk), .rst_n(rst_n), .cen(cen), .dma_go(dma_go), .busak_n(busak_n), .LVBL(LVBL),
    .busrq_n(busrq_n_a), .src_addr(src_addr_a), .src_cs(src_cs_a), .src_dout(src_dout_a),
    .obj_addr(obj_addr_a), .obj_din(obj_din_a), .obj_we(obj_we_a), .busy(busy_a));

  jtpang_objdma #(.SRC_BASE(12'hF00)) dut_b (
    .clk(clk), .rst_n(rst_n), .cen(cen), .dma_go(dma_go), .busak_n(busak_n), .LVBL(LVBL),
    .busrq_n(busrq_n_b), .src_addr(src_addr_b), .src_cs(src_cs_b), .src_dout(src_dout_b),
    .obj_addr(obj_addr_b), .obj_din(obj_din_b), .obj_we(obj_we_b), .busy(busy_b));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endfunction

  // CPU model: random cen; grants the bus 3 cen after a request, unless forced off
  initial begin
    cen = 1'b0; busak_n = 1'b1; ack_dly = 0;
    forever begin
      @(posedge clk); #1;
      cen_smp   = cen;
      busak_smp = busak_n;
      if (busrq_n_a !== 1'b0) begin
        ack_dly = 0;
        busak_n = 1'b1;
      end else begin
        if (cen_smp && ack_dly < 3) ack_dly++;
        busak_n = !(ack_dly >= 3 && !force_hi);
      end
      cen = ($urandom_range(0, 2) != 0);
    end
  end

  // Reference: the i-th write of a transfer carries byte mem[(base+i) mod 4096] to address i
  always @(negedge clk) begin
    int  ia, ib;
    bit  ok;
    if (!rst_n) begin
      wr_idx = 0;
    end else if (obj_we_a || obj_we_b) begin
      ia = wr_idx % 4096;
      ib = (3840 + wr_idx) % 4096;
      ok = obj_we_a && obj_we_b && int'(obj_addr_a) == wr_idx && int'(obj_addr_b) == wr_idx
           && obj_din_a == mem[ia] && obj_din_b == mem[ib]
           && int'(src_addr_a) == ia && int'(src_addr_b) == ib
           && src_cs_a && busy_a && !busrq_n_a && !busak_smp;
      n_cmp++;
      if (!ok) begin
        n_fail++;
        $display("FAIL write[%0d]: got we %b/%b addr %0d/%0d din %02h/%02h src %03h/%03h busak %b, expected addr %0d din %02h/%02h src %03h/%03h busak 0",
                 wr_idx, obj_we_a, obj_we_b, obj_addr_a, obj_addr_b, obj_din_a, obj_din_b,
                 src_addr_a, src_addr_b, busak_smp, wr_idx, mem[ia], mem[ib], ia[11:0], ib[11:0]);
      end
      wr_idx++;
      if (wr_idx == LEN) begin
        wr_idx = 0;
        xfers_total++;
      end
    end
  end

  task automatic pulse_go();
    @(negedge clk) dma_go = 1'b1;
    @(negedge clk) dma_go = 1'b0;
  endtask

  task automatic wait_writes(input string nm, input int n);
    int t = 0;
    while (wr_idx < n && t < 20000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 20000) chk({nm, "_wait_writes"}, wr_idx, n);
  endtask

  task automatic wait_idle(input string nm);
    int idle = 0, t = 0;
    while (idle < 30 && t < 40000) begin
      @(negedge clk);
      t++;
      if (busrq_n_a && !busy_a) idle++; else idle = 0;
    end
    if (t >= 40000) chk({nm, "_idle_timeout"}, idle, 30);
  endtask

  task automatic req_on_next_cen(input string nm);
    bit done = 0;
    for (int k = 0; k < 50 && !done; k++) begin
      @(negedge clk);
      if (cen_smp) begin
        chk(nm, busrq_n_a, 0);
        done = 1;
      end else if (busrq_n_a !== 1'b1) begin
        chk({nm, "_early"}, busrq_n_a, 1);
        done = 1;
      end
    end
    if (!done) chk({nm, "_timeout"}, busrq_n_a, 0);
  endtask

  typedef struct {
    string name;
    int    go2_at;
    int    go3_at;
    int    hold_at;
    int    rst_at;
    int    exp_xfers;
  } scen_t;

  scen_t scen [5];

  initial begin
    int base, w0, c;
    bit stuck;
    scen[0] = '{"single",     -1,  -1,  -1,  -1, 1};
    scen[1] = '{"queued",    100, 200,  -1,  -1, 2};
    scen[2] = '{"pause",      -1,  -1,  50,  -1, 1};
    scen[3] = '{"reset",      -1,  -1,  -1, 300, 1};
    scen[4] = '{"pause_last", -1,  -1, 511,  -1, 1};

    for (int i = 0; i < 4096; i++) mem[i] = 8'($urandom);
    dma_go = 1'b0; LVBL = 1'b0; rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_busrq_n", busrq_n_a, 1);
    chk("rst_src_cs", src_cs_a, 0);
    chk("rst_src_addr_a", src_addr_a, 12'h000);
    chk("rst_src_addr_b", src_addr_b, 12'hF00);
    chk("rst_obj_we", obj_we_a, 0);
    chk("rst_obj_addr", obj_addr_a, 0);
    chk("rst_obj_din", obj_din_a, 0);
    chk("rst_busy", busy_a, 0);

    for (int s = 0; s < 5; s++) begin
      base = xfers_total;
      pulse_go();
      if (scen[s].rst_at >= 0) begin
        wait_writes(scen[s].name, scen[s].rst_at);
        #2 rst_n = 1'b0;
        #1;
        chk({scen[s].name, "_busrq_n"}, busrq_n_a, 1);
        chk({scen[s].name, "_busy"}, busy_a, 0);
        chk({scen[s].name, "_obj_we"}, obj_we_a, 0);
        chk({scen[s].name, "_src_cs"}, src_cs_a, 0);
        @(negedge clk);
        @(negedge clk) rst_n = 1'b1;
        pulse_go();
      end
      if (scen[s].go2_at >= 0) begin
        wait_writes(scen[s].name, scen[s].go2_at);
        pulse_go();
      end
      if (scen[s].go3_at >= 0) begin
        wait_writes(scen[s].name, scen[s].go3_at);
        pulse_go();
      end
      if (scen[s].hold_at >= 0) begin
        wait_writes(scen[s].name, scen[s].hold_at);
        force_hi = 1'b1;
        @(negedge clk);
        #1 w0 = wr_idx;
        c = 0;
        while (c < 10) begin
          @(negedge clk);
          if (cen_smp) c++;
        end
        chk({scen[s].name, "_no_progress"}, wr_idx, w0);
        force_hi = 1'b0;
      end
      wait_idle(scen[s].name);
      chk({scen[s].name, "_xfers"}, xfers_total - base, scen[s].exp_xfers);
      chk({scen[s].name, "_released"}, busrq_n_a, 1);
    end

    // dma_go held high through a whole transfer and beyond
    base = xfers_total;
    @(negedge clk) dma_go = 1'b1;
    wait_idle("held_go");
    repeat (100) @(negedge clk);
    chk("held_go_xfers", xfers_total - base, 1);
    dma_go = 1'b0;

    // request latency and blanking gate
    base = xfers_total;
    LVBL = 1'b1;
    pulse_go();
`ifdef JTPANG_DMA_LVBL_EN
    stuck = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (busrq_n_a !== 1'b1) stuck = 1;
    end
    chk("lvbl_wait_busrq", stuck, 0);
    LVBL = 1'b0;
    req_on_next_cen("lvbl_req_on_blank");
    repeat (20) @(negedge clk);
    LVBL = 1'b1;
`else
    req_on_next_cen("req_next_cen");
`endif
    wait_idle("lvbl");
    chk("lvbl_xfers", xfers_total - base, 1);
    LVBL = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
